// File: rtl/top_puf.sv
// Dual-core adder PUF: operands registered, per-bit carry-chain race between two
// delay-weighted cores resolved by an arbiter, response registered (latency 2).
module top_puf #(
  parameter int unsigned  D0      = 2,
  parameter int unsigned  D1      = 3,
  parameter logic [127:0] OFFSET0 = {32{4'd5}},
  parameter logic [127:0] OFFSET1 = {32{4'd3}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  logic [31:0] ra_q, rb_q, c_q;
  logic [31:0] r_d;
  logic [31:0] sum, gen, prop;
  logic [4:0]  len  [32];
  logic [9:0]  t0   [32];
  logic [9:0]  t1   [32];

  // Length of the carry chain feeding bit i: walk down from i-1 through
  // propagating bits; only a generating bit at the stop point yields a chain.
  function automatic logic [4:0] chain_len(input logic [31:0] g, input logic [31:0] p,
                                           input int unsigned i);
    logic [4:0]  l;
    logic        stop;
    int unsigned j;
    l    = '0;
    stop = 1'b0;
    for (int unsigned k = 0; k < i; k++) begin
      j = i - 1 - k;
      if (!stop && !p[j]) begin
        stop = 1'b1;
        if (g[j]) l = 5'(i - j);
      end
    end
    return l;
  endfunction

  always_comb begin
    sum  = ra_q + rb_q;
    gen  = ra_q & rb_q;
    prop = ra_q ^ rb_q;
    r_d  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      len[i] = chain_len(gen, prop, i);
      t0[i]  = 10'(D0) * 10'(len[i]) + 10'(OFFSET0[4*i +: 4]);
      t1[i]  = 10'(D1) * 10'(len[i]) + 10'(OFFSET1[4*i +: 4]);
      if (t0[i] < t1[i])      r_d[i] = 1'b1;
      else if (t0[i] > t1[i]) r_d[i] = 1'b0;
      else                    r_d[i] = sum[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ra_q <= '0;
      rb_q <= '0;
      c_q  <= '0;
    end else begin
      ra_q <= a;
      rb_q <= b;
      c_q  <= r_d;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_top_puf.sv
// Directed self-checking bench for top_puf with default parameters.
module tb_top_puf;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [31:0] c;

  int n_checks = 0;
  int n_fail   = 0;

  top_puf dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    #2;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: got=%h exp=%h", c, 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held_clocked: got=%h exp=%h", c, 32'h0);
    end
    @(negedge clk);
    a = '0;
    b = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_operands: got=%h exp=%h", c, 32'h0);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [8] = '{32'h0000_0000, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_0001,
                            32'h0000_00FF, 32'h0000_0030, 32'h0000_000F, 32'h8000_0000};
    logic [31:0] vb [8] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                            32'h0000_0001, 32'h0000_0010, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] ve [8] = '{32'h0000_0000, 32'h0000_0018, 32'hFFFF_FFF8, 32'h0000_0000,
                            32'h0000_01F8, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++;
      if (c !== ve[i]) begin
        n_fail++;
        $display("FAIL vector_%0d a=%h b=%h: got=%h exp=%h", i, va[i], vb[i], c, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] vb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    logic [31:0] ve [3] = '{32'h0000_0018, 32'hFFFF_FFF8, 32'h0000_0000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        a = va[k];
        b = vb[k];
      end else begin
        a = '0;
        b = '0;
      end
      @(posedge clk);
      #1;
      if (k >= 1) begin
        n_checks++;
        if (c !== ve[k-1]) begin
          n_fail++;
          $display("FAIL back_to_back_%0d: got=%h exp=%h", k - 1, c, ve[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL midstream_pre: got=%h exp=%h", c, 32'hFFFF_FFF8);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL midstream_async_clear: got=%h exp=%h", c, 32'h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL midstream_held: got=%h exp=%h", c, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL midstream_first_edge: got=%h exp=%h", c, 32'h0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (c !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL midstream_recovered: got=%h exp=%h", c, 32'hFFFF_FFF8);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top_puf.md
TOP_PUF -- requirements
Module: top_puf

Interface
- REQ-001: Parameter D0, default 2: per-carry-stage delay weight of core 0.
- REQ-002: Parameter D1, default 3: per-carry-stage delay weight of core 1.
- REQ-003: Parameter OFFSET0, 128 bits, default {32{4'd5}}: 4-bit static delay offset per bit i of core 0, held in bits [4i+3:4i].
- REQ-004: Parameter OFFSET1, 128 bits, default {32{4'd3}}: 4-bit static delay offset per bit i of core 1, same packing.
- REQ-005: clk  input  1  sole clock; all state updates on rising edge.
- REQ-006: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- REQ-007: a  input  32  adder operand A (challenge half).
- REQ-008: b  input  32  adder operand B (challenge half).
- REQ-009: c  output  32  registered PUF response word.

Function
- REQ-010: The block SHALL model a dual-core adder PUF; both cores compute s = a + b (mod 2^32) on the same operands and race per sum bit.
- REQ-011: Stage 1 SHALL register a and b into internal registers ra and rb on every rising clk edge; there is no enable.
- REQ-012: From ra and rb, per bit j: generate g[j] = ra[j] & rb[j]; propagate p[j] = ra[j] ^ rb[j].
- REQ-013: Carry-chain length L(i) for bit i: scan j = i-1 down to 0; stop at the first j with p[j] = 0; if g[j] = 1 there, L(i) = i - j; otherwise L(i) = 0; if no stop is found, L(i) = 0; L(0) = 0.
- REQ-014: Arrival time tk(i) = Dk*L(i) + OFFSETk[4i+3:4i], for k = 0 and k = 1, computed unsigned with at least 8 bits and no overflow for the default parameters.
- REQ-015: Arbiter rule: response bit r[i] = 1 if t0(i) < t1(i); 0 if t0(i) > t1(i); on a tie, r[i] = s[i], where s = ra + rb.
- REQ-016: Stage 2 SHALL register r into c on the next rising edge; c reflects the a and b sampled 2 edges earlier (latency 2, throughput 1 per clock).
- REQ-017: The L, t and r computation between the stages SHALL be purely combinational and deterministic, with no hidden state.
- REQ-018: Operand changes on consecutive cycles SHALL produce back-to-back independent responses with no interaction between them.
- REQ-019: The sum carry-out SHALL be discarded; the wrap-around of a + b does not affect L(i).

Reset
- REQ-020: While reset = 0, ra, rb and c SHALL be 0, asynchronously and immediately, regardless of clk.
- REQ-021: Asserting reset mid-stream SHALL discard in-flight operands.
- REQ-022: After reset deasserts, the first valid c appears 2 edges after the first sampled operands.
- REQ-023: Until that point, c SHALL read 0x00000000; with default parameters, all-zero operands give response 0 anyway.

Verification (default parameters)
- REQ-024: a = 0x00000000, b = 0x00000000 -> c = 0x00000000 two edges later (L = 0 everywhere, so t0 = 5 > t1 = 3).
- REQ-025: a = 0x0000000F, b = 0x00000001 -> c = 0x00000018 (bit 2 tie gives s[2] = 0; bits 3 and 4 have L = 3 and 4; bit 5 is killed).
- REQ-026: a = 0xFFFFFFFF, b = 0x00000001 -> c = 0xFFFFFFF8 (L(i) = i; bit 2 tie with s = 0).
- REQ-027: a = 0x00000001, b = 0x00000001 -> c = 0x00000000 (bit 1 has L = 1: 7 vs 6).
- REQ-028: Apply the three operand pairs of REQ-025, REQ-026 and REQ-027 on consecutive cycles -> c = 0x00000018, 0xFFFFFFF8 and 0x00000000 on consecutive cycles.
- REQ-029: Pulse reset low asynchronously between clock edges while c = 0xFFFFFFF8 -> c = 0 immediately and stays 0 until 2 edges after reset is released.
